axi4_bram_slave: RTL
====================

# axi4_bram_slave

AXI4 slave wrapping a MEM_DEPTH x MEM_WIDTH block RAM. It is the downstream endpoint behind the interconnect that the polynomial-coefficient masters read from and write back to. Read and write channels run as independent state machines over a dual-access array. It supports FIXED, INCR and (optionally) WRAP bursts with transaction-ID echo and OKAY/SLVERR responses.

## Interface
- MEM_WIDTH, 8: data/word width in bits
- MEM_DEPTH, 32: number of words
- ADDR_LEN, 5: address width, log2(MEM_DEPTH)

- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  reset, asynchronous, active-low
- ARID / ARADDR / ARLEN / ARSIZE / ARBURST  in  4 / ADDR_LEN / 8 / 3 / 2  read address
- ARVALID  in  1;  ARREADY  out  1
- RID  out  4;  RDATA  out  MEM_WIDTH;  RRESP  out  2;  RLAST  out  1;  RVALID  out  1;  RREADY  in  1
- AWID / AWADDR / AWLEN / AWSIZE / AWBURST  in  4 / ADDR_LEN / 8 / 3 / 2  write address
- AWVALID  in  1;  AWREADY  out  1
- WID  in  4;  WDATA  in  MEM_WIDTH;  WLAST  in  1;  WVALID  in  1;  WREADY  out  1
- BID  out  4;  BRESP  out  2;  BVALID  out  1;  BREADY  in  1

## Operation
- Reset (ARESET=0, async): all outputs 0; both FSMs to IDLE; memory contents not altered. Reset mid-burst abandons it; beats already written stay written.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY, capture ID/addr/len/size/burst, clear beat count, ARREADY=0, go R_DATA.
  - R_DATA: RVALID=1, RDATA=mem[addr], RID=captured ID, RLAST=(beat==len). On RVALID&RREADY, advance address per burst type and beat+1. On the last beat, go R_IDLE.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1. On handshake, capture fields and go W_DATA.
  - W_DATA: WREADY=1. Each WVALID&WREADY writes WDATA to mem[addr] unless the burst is flagged error. The burst ends after AWLEN+1 beats, counted. WLAST is not used for termination; masters drop WVALID with WLAST. A beat whose WID differs from the captured AWID is dropped and sets the error flag.
  - W_RESP: BVALID=1, BID=captured AWID, BRESP=OKAY, or SLVERR if the error flag is set. On BREADY, go W_IDLE.
- Address update:
  - FIXED: hold.
  - INCR: addr+1 modulo MEM_DEPTH, so 31 wraps to 0.
  - WRAP: increment within the aligned block of (len+1) words.
- SLVERR conditions (burst still runs to full beat count):
  - ARSIZE/AWSIZE != 0.
  - Burst type 2'b11.
  - WRAP with len+1 not in {2,4,8,16}.
  - On error, reads return RDATA=0 and writes are suppressed.
- Simultaneous read and write to the same address in one cycle: read returns the old word (read-before-write).
- Read and write bursts may be in flight concurrently; neither channel stalls the other.

## Timing
- ARREADY/AWREADY rise at the first ACLK edge after ARESET deasserts.
- AR handshake at edge N: first RVALID at edge N+1, so 1-cycle latency. With RREADY held high, one beat per cycle, and (len+1) beats finish at edge N+len+1.
- After the last R handshake at edge M: RVALID=0 and ARREADY=1 at edge M+1. At most one AR is accepted per burst, with no outstanding queue.
- AW handshake at edge N: WREADY=1 from edge N+1.
- After the last W beat at edge M: WREADY=0 and BVALID=1 at edge M+1. BVALID holds until BREADY, then AWREADY=1 at the following edge.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- AXI_WRAP_BURST_EN defined: WRAP bursts operate as above.
- Not defined: any WRAP request (2'b10) is treated as an illegal burst type. It gets a SLVERR response with the full beat count, reads return 0, and writes are suppressed.

## Test plan
- Write then read: INCR write, AWID=0, addr 0, AWLEN=3, data {2,5,4,3} -> BID=0, BRESP=00. Then INCR read of the same range, ARID=1 -> RDATA 2,5,4,3, RLAST on beat 4, RID=1, RRESP=00.
- INCR wrap-around: read of ARADDR=30, ARLEN=3 -> words from addresses 30,31,0,1.
- WRAP burst (with AXI_WRAP_BURST_EN): read ARADDR=6, ARLEN=3 -> addresses 6,7,4,5. Without the macro -> RRESP=10 on all beats, RDATA=0.
- Errors:
  - AWSIZE=1 burst -> BRESP=10 and memory unchanged.
  - WID != AWID on one beat -> BRESP=10 and that beat not written.
- Backpressure and concurrency: RREADY toggled 1/0 during a 4-beat read -> RDATA/RLAST held stable while stalled. Concurrent write burst -> completes independently.
- Reset mid-read at beat 2 -> RVALID=0 immediately. ARREADY=1 one edge after release. The next read returns correct data.

Source files
------------

// File: rtl/axi4_bram_slave.sv
// AXI4 slave over a MEM_DEPTH x MEM_WIDTH RAM with independent read and write burst FSMs.
// Define AXI_WRAP_BURST_EN to enable WRAP bursts; otherwise WRAP is answered with SLVERR.
module axi4_bram_slave #(
  parameter int unsigned MEM_WIDTH = 8,
  parameter int unsigned MEM_DEPTH = 32,
  parameter int unsigned ADDR_LEN  = 5
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [3:0]           ARID,
  input  logic [ADDR_LEN-1:0]  ARADDR,
  input  logic [7:0]           ARLEN,
  input  logic [2:0]           ARSIZE,
  input  logic [1:0]           ARBURST,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  output logic [3:0]           RID,
  output logic [MEM_WIDTH-1:0] RDATA,
  output logic [1:0]           RRESP,
  output logic                 RLAST,
  output logic                 RVALID,
  input  logic                 RREADY,
  input  logic [3:0]           AWID,
  input  logic [ADDR_LEN-1:0]  AWADDR,
  input  logic [7:0]           AWLEN,
  input  logic [2:0]           AWSIZE,
  input  logic [1:0]           AWBURST,
  input  logic                 AWVALID,
  output logic                 AWREADY,
  input  logic [3:0]           WID,
  input  logic [MEM_WIDTH-1:0] WDATA,
  input  logic                 WLAST,
  input  logic                 WVALID,
  output logic                 WREADY,
  output logic [3:0]           BID,
  output logic [1:0]           BRESP,
  output logic                 BVALID,
  input  logic                 BREADY
);

`ifdef AXI_WRAP_BURST_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic {RIdle, RData} r_state_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
    logic len_ok;
    len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size != 3'd0) || (burst == 2'b11) || ((burst == BurstWrap) && (!WrapEn || !len_ok));
  endfunction

  // WRAP keeps the upper address bits and counts the low bits modulo (len+1).
  function automatic logic [ADDR_LEN-1:0] next_addr(input logic [ADDR_LEN-1:0] addr,
                                                    input logic [1:0] burst,
                                                    input logic [7:0] len);
    logic [ADDR_LEN-1:0] mask;
    logic [ADDR_LEN-1:0] inc;
    mask = ADDR_LEN'(len);
    inc  = addr + ADDR_LEN'(1);
    case (burst)
      BurstIncr: return inc;
      BurstWrap: return (addr & ~mask) | (inc & mask);
      default:   return addr;
    endcase
  endfunction

  // Read channel
  r_state_e             r_state_q, r_state_d;
  logic [3:0]           r_id_q, r_id_d;
  logic [ADDR_LEN-1:0]  r_addr_q, r_addr_d;
  logic [7:0]           r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic [1:0]           r_burst_q, r_burst_d, rresp_q, rresp_d;
  logic                 r_err_q, r_err_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic                 rlast_q, rlast_d;
  logic [MEM_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_burst_d = r_burst_q;
    r_err_d   = r_err_q;
    r_beat_d  = r_beat_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      RIdle: begin
        if (ARVALID && arready_q) begin
          r_state_d = RData;
          r_id_d    = ARID;
          r_addr_d  = ARADDR;
          r_len_d   = ARLEN;
          r_burst_d = ARBURST;
          r_err_d   = burst_err(ARSIZE, ARBURST, ARLEN);
          r_beat_d  = 8'd0;
          rresp_d   = r_err_d ? RespSlverr : RespOkay;
          rlast_d   = (ARLEN == 8'd0);
          rdata_d   = r_err_d ? '0 : mem[ARADDR];
        end
      end
      RData: begin
        if (RREADY && rvalid_q) begin
          if (r_beat_q == r_len_q) begin
            r_state_d = RIdle;
            rlast_d   = 1'b0;
          end else begin
            // Sampling the array here gives read-before-write against a same-edge write.
            r_addr_d = next_addr(r_addr_q, r_burst_q, r_len_q);
            r_beat_d = r_beat_q + 8'd1;
            rlast_d  = (r_beat_d == r_len_q);
            rdata_d  = r_err_q ? '0 : mem[r_addr_d];
          end
        end
      end
    endcase
    arready_d = (r_state_d == RIdle);
    rvalid_d  = (r_state_d == RData);
  end

  // Write channel
  w_state_e            w_state_q, w_state_d;
  logic [3:0]          w_id_q, w_id_d, bid_q, bid_d;
  logic [ADDR_LEN-1:0] w_addr_q, w_addr_d;
  logic [7:0]          w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic [1:0]          w_burst_q, w_burst_d, bresp_q, bresp_d;
  logic                w_err_q, w_err_d, awready_q, awready_d, wready_q, wready_d;
  logic                bvalid_q, bvalid_d, mem_we;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_burst_d = w_burst_q;
    w_err_d   = w_err_q;
    w_beat_d  = w_beat_q;
    unique case (w_state_q)
      WIdle: begin
        if (AWVALID && awready_q) begin
          w_state_d = WData;
          w_id_d    = AWID;
          w_addr_d  = AWADDR;
          w_len_d   = AWLEN;
          w_burst_d = AWBURST;
          w_err_d   = burst_err(AWSIZE, AWBURST, AWLEN);
          w_beat_d  = 8'd0;
        end
      end
      WData: begin
        // Termination is by beat count; WLAST is not consulted.
        if (WVALID && wready_q) begin
          if (WID != w_id_q) w_err_d = 1'b1;
          w_addr_d = next_addr(w_addr_q, w_burst_q, w_len_q);
          w_beat_d = w_beat_q + 8'd1;
          if (w_beat_q == w_len_q) w_state_d = WResp;
        end
      end
      WResp: begin
        if (BREADY && bvalid_q) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
    awready_d = (w_state_d == WIdle);
    wready_d  = (w_state_d == WData);
    bvalid_d  = (w_state_d == WResp);
    bid_d     = w_id_d;
    bresp_d   = w_err_d ? RespSlverr : RespOkay;
  end

  assign mem_we = wready_q && WVALID && !w_err_q && (WID == w_id_q);

  always_ff @(posedge ACLK) begin
    if (mem_we) mem[w_addr_q] <= WDATA;
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      r_state_q <= RIdle;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_err_q   <= 1'b0;
      r_beat_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      w_beat_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_burst_q <= r_burst_d;
      r_err_q   <= r_err_d;
      r_beat_q  <= r_beat_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
      w_beat_q  <= w_beat_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  logic unused_wlast;
  assign unused_wlast = WLAST;

  assign ARREADY = arready_q;
  assign RID     = r_id_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;
  assign RVALID  = rvalid_q;
  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign BVALID  = bvalid_q;

endmodule
